fir_input_sequencer: RTL and testbench

Upstream stage of the FIR top level. Debounces the run/stop push button and toggles a run mode. While running, emits a paced stream of test samples to the FIR core over a valid/ready handshake. Drives the run-status LED and flags samples dropped because the FIR was not ready.

---
 rtl/fir_seq_pkg.sv | 18 +
 rtl/fir_input_sequencer_btn_debounce.sv | 35 +++
 rtl/fir_input_sequencer.sv | 102 ++++++++++
 tb/tb_fir_input_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared FSM states, LFSR tap masks and default timing constants for fir_input_sequencer
package fir_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_SAMPLE_DIV      = 50000;

    // Right-shifting Galois masks for maximal-length sequences
    localparam logic [15:0] LFSR_TAPS_8  = 16'h00B8;
    localparam logic [15:0] LFSR_TAPS_12 = 16'h0E08;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

    function automatic logic [15:0] lfsr_taps(input int w);
        return w == 8 ? LFSR_TAPS_8 : w == 12 ? LFSR_TAPS_12 : w == 16 ? LFSR_TAPS_16 : 16'h0000;
    endfunction

endpackage

// File: rtl/fir_input_sequencer_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-level debounce and one-cycle press pulse on accepted 0->1
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          settled;

    // cnt counts consecutive cycles the synchronized level has disagreed with the accepted one
    assign settled = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            cnt   <= (sync[1] == level || settled) ? '0 : cnt + CW'(1);
            level <= settled ? sync[1] : level;
            press <= settled & sync[1];
        end
    end

endmodule

// File: rtl/fir_input_sequencer.sv
// fir_input_sequencer: run/stop FSM pacing ramp samples (LFSR when FIR_SEQ_LFSR_EN) to the FIR core
module fir_input_sequencer
    import fir_seq_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SAMPLE_DIV      = DEF_SAMPLE_DIV,
    parameter int RAMP_STEP       = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              toggleBtn,
    input  logic              sample_ready,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    output logic              running,
    output logic              overrun
);

    localparam int DW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;

    seq_state_t        state;
    logic [DW-1:0]     div_cnt;
    logic [DATA_W-1:0] gen;
    logic [DATA_W-1:0] gen_next;
    logic              press;
    logic              tick;
    logic              xfer;

`ifdef FIR_SEQ_LFSR_EN
    localparam logic [DATA_W-1:0] SEED = DATA_W'(1);
    localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

    generate
        if (DATA_W != 8 && DATA_W != 12 && DATA_W != 16) begin : g_bad_width
            $error("fir_input_sequencer: LFSR supports DATA_W of 8, 12 or 16 only");
        end
    endgenerate

    assign gen_next = (gen >> 1) ^ (gen[0] ? TAPS : '0);
`else
    localparam logic [DATA_W-1:0] SEED = '0;

    assign gen_next = gen + DATA_W'(RAMP_STEP);
`endif

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .btn   (toggleBtn),
        .press (press)
    );

    assign tick = (state == RUN) && (div_cnt == DW'(SAMPLE_DIV - 1));
    assign xfer = sample_valid & sample_ready;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            div_cnt      <= '0;
            gen          <= SEED;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            running      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        state   <= RUN;
                        running <= 1'b1;
                        div_cnt <= '0;
                    end
                end
                RUN: begin
                    div_cnt <= tick ? '0 : div_cnt + DW'(1);
                    // A sample leaving this cycle frees the slot, so the tick may refill it
                    if (tick && (!sample_valid || xfer)) begin
                        sample_data  <= gen;
                        gen          <= gen_next;
                        sample_valid <= 1'b1;
                    end else begin
                        if (tick) overrun <= 1'b1;
                        if (xfer) sample_valid <= 1'b0;
                    end
                    if (press) begin
                        state   <= DRAIN;
                        running <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!sample_valid || xfer) begin
                        state        <= IDLE;
                        sample_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_input_sequencer.sv
// tb_fir_input_sequencer: directed checks of debounce, pacing, backpressure, drain, wrap and async reset
module tb_fir_input_sequencer;
    import fir_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       ready;
    logic [7:0] data, data64;
    logic       valid, valid64;
    logic       running, running64;
    logic       overrun, overrun64;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n;

    always #5 clk = ~clk;

    fir_input_sequencer #(.DATA_W(8), .DEBOUNCE_CYCLES(4), .SAMPLE_DIV(8), .RAMP_STEP(1)) dut (
        .CLOCK_50     (clk),
        .reset_n      (rst_n),
        .toggleBtn    (btn),
        .sample_ready (ready),
        .sample_data  (data),
        .sample_valid (valid),
        .running      (running),
        .overrun      (overrun)
    );

    fir_input_sequencer #(.DATA_W(8), .DEBOUNCE_CYCLES(4), .SAMPLE_DIV(8), .RAMP_STEP(64)) dut64 (
        .CLOCK_50     (clk),
        .reset_n      (rst_n),
        .toggleBtn    (btn),
        .sample_ready (ready),
        .sample_data  (data64),
        .sample_valid (valid64),
        .running      (running64),
        .overrun      (overrun64)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int exp_s(input int k, input int step);
`ifdef FIR_SEQ_LFSR_EN
        logic [7:0] s;
        s = 8'h01;
        for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
        return int'(s) + 0 * step;
`else
        return (k * step) % 256;
`endif
    endfunction

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!valid && cyc < 40);
        chk(tag, int'(valid), 1);
    endtask

    // Press latency: 2 sync + 4 debounce registers the pulse, FSM reacts one edge later
    task automatic press(input string tag);
        int   c;
        logic r0;
        r0  = running;
        btn = 1'b1;
        c   = 0;
        while (running == r0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        btn = 1'b0;
        chk(tag, c, 7);
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Bounce 1,0,1 then held: one press, latency from the stable edge
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
        btn = 1'b1;
        n = 0;
        while (!running && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bounce_latency", n, 7);
        repeat (3) @(negedge clk);
        btn = 1'b0;

        // Streaming with ready tied high
        wait_valid("first_valid", n);
        chk("first_tick_latency", n, 5);
        chk("stream_data0", int'(data), exp_s(0, 1));
        @(negedge clk);
        chk("stream_pulse0", int'(valid), 0);
        for (int k = 1; k < 4; k++) begin
            wait_valid("stream_valid", n);
            chk("stream_period", n, 7);
            chk("stream_data", int'(data), exp_s(k, 1));
            @(negedge clk);
            chk("stream_pulse", int'(valid), 0);
        end
        chk("stream_overrun", int'(overrun), 0);
        chk("stream_running", int'(running), 1);

        // Async reset between edges clears outputs at once
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_data", int'(data), 0);
        chk("async_running", int'(running), 0);
        chk("async_valid", int'(valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b0;
        repeat (2) @(negedge clk);

        // Backpressure: sample held, second tick sets overrun
        press("press_bp");
        wait_valid("bp_valid", n);
        chk("bp_first_latency", n, 8);
        chk("bp_data0", int'(data), exp_s(0, 1));
        chk("bp_overrun_pre", int'(overrun), 0);
        repeat (8) @(negedge clk);
        chk("bp_overrun", int'(overrun), 1);
        chk("bp_valid_held", int'(valid), 1);
        chk("bp_data_held", int'(data), exp_s(0, 1));
        repeat (4) @(negedge clk);
        chk("bp_data_held2", int'(data), exp_s(0, 1));
        ready = 1'b1;
        @(negedge clk);
        chk("bp_drop", int'(valid), 0);
        wait_valid("bp_next_valid", n);
        chk("bp_next_data", int'(data), exp_s(1, 1));
        chk("bp_overrun_sticky", int'(overrun), 1);

        // Stop while a sample is pending, then drain on handshake
        ready = 1'b0;
        press("press_stop");
        chk("drain_running", int'(running), 0);
        chk("drain_state", int'(dut.state), int'(DRAIN));
        chk("drain_valid", int'(valid), 1);
        repeat (10) @(negedge clk);
        chk("drain_valid_hold", int'(valid), 1);
        chk("drain_data_hold", int'(data), exp_s(1, 1));
        ready = 1'b1;
        @(negedge clk);
        chk("drain_done_valid", int'(valid), 0);
        chk("drain_done_state", int'(dut.state), int'(IDLE));
        press("press_restart");
        wait_valid("restart_valid", n);
        chk("restart_data", int'(data), exp_s(2, 1));

        // Short glitch must not start a run
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_running", int'(running), 0);

        // Wrap with RAMP_STEP=64
        press("press_wrap");
        for (int k = 0; k < 5; k++) begin
            wait_valid("wrap_valid", n);
            chk("wrap_valid64", int'(valid64), 1);
            chk("wrap_data64", int'(data64), exp_s(k, 64));
            @(negedge clk);
        end
        chk("wrap_overrun64", int'(overrun64), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
